// File: rtl/pico_alu_pkg.sv
// ============================================================================
// pico_alu_pkg : opcode encoding, arbiter FSM states and opcode helpers
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pico_alu_pkg;

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // MUL and DIV are allowed to run as multicycle paths through the alu
    function automatic logic is_slow_op(input logic [2:0] oc);
        return (oc == OC_MUL) || (oc == OC_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// alu_rr_arbiter : combinational 2-way round-robin grant
// Revision       : 1.0
// ============================================================================
`default_nettype none

module alu_rr_arbiter (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_o
);

    always_comb begin
        grant_valid_o = |valid_i;
        grant_o       = 1'b0;
        // On contention the requester that did not win last time is picked
        if (valid_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else if (valid_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : shares one combinational alu between two valid/ready requesters
//               Optional macro ALU_ARB_DZ_EN enables divide-by-zero reporting.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import pico_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FAST_LAT   = 1,
    parameter int SLOW_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_oc,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_f,
    output logic                  rsp0_err,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_oc,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_f,
    output logic                  rsp1_err,
    output logic [2:0]            alu_oc,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_f
);

    localparam int MAX_LAT = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              oc_q, oc_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    logic                    gnt_vld;
    logic                    gnt;
    logic [2:0]              sel_oc;
    logic                    dz;

    alu_rr_arbiter u_rr (
        .valid_i       ({req1_valid, req0_valid}),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (gnt_vld),
        .grant_o       (gnt)
    );

    assign sel_oc = gnt ? req1_oc : req0_oc;

`ifdef ALU_ARB_DZ_EN
    assign dz = (oc_q == OC_DIV) && (b_q == '0);
`else
    assign dz = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        oc_d         = oc_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt;
                    oc_d    = sel_oc;
                    a_d     = gnt ? req1_a : req0_a;
                    b_d     = gnt ? req1_b : req0_b;
                    cnt_d   = is_slow_op(sel_oc) ? CNT_W'(SLOW_LAT) : CNT_W'(FAST_LAT);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = dz ? '0 : alu_f;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            oc_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            oc_q         <= oc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
        end
    end

    // Ready is gated by reset so nothing is accepted while rst_n is held low
    assign req0_ready = rst_n && (state_q == IDLE) && gnt_vld && !gnt;
    assign req1_ready = rst_n && (state_q == IDLE) && gnt_vld &&  gnt;

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) &&  owner_q;
    assign rsp0_f     = result_q;
    assign rsp1_f     = result_q;
    assign rsp0_err   = rsp0_valid && dz;
    assign rsp1_err   = rsp1_valid && dz;

    assign alu_oc = oc_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : scoreboard testbench for alu_arbiter with a behavioural alu
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import pico_alu_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [2:0]    req0_oc, req1_oc, alu_oc;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_f, rsp1_f;
    logic [DW-1:0] alu_a, alu_b, alu_f;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic          id;
        logic [DW-1:0] f;
        logic          err;
    } exp_t;
    exp_t sb[$];

    alu_arbiter #(.DATA_WIDTH(DW), .FAST_LAT(1), .SLOW_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_oc(req0_oc),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_f(rsp0_f), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_oc(req1_oc),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_f(rsp1_f), .rsp1_err(rsp1_err),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural alu; divide by zero yields all ones
    always_comb begin
        alu_f = '0;
        case (alu_oc)
            OC_ADD:  alu_f = alu_a + alu_b;
            OC_SUB:  alu_f = alu_a - alu_b;
            OC_MUL:  alu_f = alu_a * alu_b;
            OC_DIV:  alu_f = (alu_b == '0) ? '1 : alu_a / alu_b;
            OC_NOT:  alu_f = ~alu_a;
            OC_XOR:  alu_f = alu_a ^ alu_b;
            OC_OR:   alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    task automatic set_req(input logic id, input logic [2:0] oc, input logic [DW-1:0] a, b);
        if (id) begin req1_valid = 1'b1; req1_oc = oc; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_oc = oc; req0_a = a; req0_b = b; end
    endtask

    // Presents a request at the next falling edge and waits for the handshake
    task automatic issue(input logic id, input logic [2:0] oc, input logic [DW-1:0] a, b,
                         output bit ok, output int hs, output int tries, output logic other_rdy);
        ok = 1'b0; hs = 0; tries = 0; other_rdy = 1'b0;
        @(negedge clk);
        set_req(id, oc, a, b);
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            tries++;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                hs = cyc;
                other_rdy = id ? req0_ready : req1_ready;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        // Scramble the request after the handshake; the DUT must ignore it
        if (id) begin req1_valid = 1'b0; req1_oc = ~oc; req1_a = 16'hDEAD; req1_b = 16'hDEAD; end
        else    begin req0_valid = 1'b0; req0_oc = ~oc; req0_a = 16'hDEAD; req0_b = 16'hDEAD; end
    endtask

    task automatic collect(input logic id, output bit ok, output int vc,
                           output logic [DW-1:0] f, output logic err, output logic other_v);
        ok = 1'b0; vc = 0; f = '0; err = 1'b0; other_v = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            #1;
            if ((id ? rsp1_valid : rsp0_valid) === 1'b1) begin
                ok = 1'b1;
                vc = cyc;
                f = id ? rsp1_f : rsp0_f;
                err = id ? rsp1_err : rsp0_err;
                other_v = id ? rsp0_valid : rsp1_valid;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        e = '{1'bx, 'x, 1'bx};
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic test_reset();
        bit ok; int hs, tries, vc; logic orr, ov, err; logic [DW-1:0] f; exp_t e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err});
        end
        total++;
        if ({rsp0_f, rsp1_f, alu_oc, alu_a, alu_b} !== '0) begin
            bad++;
            $display("FAIL reset_data: rsp0_f=%h rsp1_f=%h oc=%h a=%h b=%h want all 0",
                     rsp0_f, rsp1_f, alu_oc, alu_a, alu_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, OC_ADD, 16'd3, 16'd4, ok, hs, tries, orr);
        sb.push_back('{1'b0, 16'd7, 1'b0});
        total++;
        if (!ok || tries != 1) begin
            bad++;
            $display("FAIL reset_first_ready: ok=%0d tries=%0d want ok=1 tries=1", ok, tries);
        end
        collect(1'b0, ok, vc, f, err, ov);
        pop_exp(e);
        total++;
        if (!ok || (vc - hs) != 2) begin
            bad++;
            $display("FAIL reset_add_latency: ok=%0d lat=%0d want 2", ok, vc - hs);
        end
        total++;
        if ({f, err, ov} !== {e.f, e.err, 1'b0}) begin
            bad++;
            $display("FAIL reset_add_result: f=%h err=%b other=%b want f=%h err=%b other=0",
                     f, err, ov, e.f, e.err);
        end
    endtask

    task automatic test_contention();
        bit ok; int hs, tries, vc; logic orr, ov, err; logic [DW-1:0] f; exp_t e;
        logic [DW-1:0] exp_f [4] = '{16'd7, 16'h00F0, 16'h0FF0, 16'hFF00};
        logic          exp_id[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0;
        @(negedge clk);
        set_req(1'b1, OC_AND, 16'hF0F0, 16'h0FF0);
        set_req(1'b0, OC_SUB, 16'd10, 16'd3);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL cont_ready_in_reset: got %b want 00", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: issue(1'b0, OC_SUB, 16'd10, 16'd3, ok, hs, tries, orr);
                1: issue(1'b1, OC_AND, 16'hF0F0, 16'h0FF0, ok, hs, tries, orr);
                2: begin
                    set_req(1'b1, OC_NOT, 16'h00FF, 16'h0000);
                    issue(1'b0, OC_OR, 16'h0F00, 16'h00F0, ok, hs, tries, orr);
                end
                default: issue(1'b1, OC_NOT, 16'h00FF, 16'h0000, ok, hs, tries, orr);
            endcase
            sb.push_back('{exp_id[k], exp_f[k], 1'b0});
            total++;
            if (!ok || orr !== 1'b0 || (k != 3 && tries != 1)) begin
                bad++;
                $display("FAIL cont_grant_%0d: ok=%0d tries=%0d other_ready=%b want ok=1 other_ready=0",
                         k, ok, tries, orr);
            end
            collect(exp_id[k], ok, vc, f, err, ov);
            pop_exp(e);
            total++;
            if (!ok || {f, err, ov} !== {e.f, e.err, 1'b0} || (vc - hs) != 2) begin
                bad++;
                $display("FAIL cont_result_%0d: ok=%0d f=%h err=%b other=%b lat=%0d want f=%h err=0 lat=2",
                         k, ok, f, err, ov, vc - hs, e.f);
            end
        end
    endtask

    task automatic test_slow_op();
        bit ok; int hs, tries, vc; logic orr, ov, err; logic [DW-1:0] f; exp_t e;
        issue(1'b1, OC_DIV, 16'd100, 16'd7, ok, hs, tries, orr);
        sb.push_back('{1'b1, 16'd14, 1'b0});
        collect(1'b1, ok, vc, f, err, ov);
        pop_exp(e);
        total++;
        if (!ok || (vc - hs) != 5) begin
            bad++;
            $display("FAIL slow_div_latency: ok=%0d lat=%0d want 5", ok, vc - hs);
        end
        total++;
        if ({f, err, ov} !== {e.f, e.err, 1'b0}) begin
            bad++;
            $display("FAIL slow_div_result: f=%h err=%b want f=%h err=%b", f, err, e.f, e.err);
        end
        issue(1'b0, OC_MUL, 16'd300, 16'd300, ok, hs, tries, orr);
        sb.push_back('{1'b0, 16'h5F90, 1'b0});
        collect(1'b0, ok, vc, f, err, ov);
        pop_exp(e);
        total++;
        if (!ok || (vc - hs) != 5 || {f, err} !== {e.f, e.err}) begin
            bad++;
            $display("FAIL slow_mul: ok=%0d lat=%0d f=%h want lat=5 f=%h", ok, vc - hs, f, e.f);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int hs, tries, vc; logic orr, ov, err; logic [DW-1:0] f; exp_t e;
        bit seen;
        rsp0_ready = 1'b0;
        issue(1'b0, OC_XOR, 16'h1234, 16'h00FF, ok, hs, tries, orr);
        sb.push_back('{1'b0, 16'h12CB, 1'b0});
        set_req(1'b1, OC_ADD, 16'd5, 16'd6);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (rsp0_valid === 1'b1);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL bp_rsp_timeout: rsp0_valid never rose");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({rsp0_valid, rsp0_f, req1_ready} !== {1'b1, 16'h12CB, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold_%0d: valid=%b f=%h req1_ready=%b want 1 12cb 0",
                         i, rsp0_valid, rsp0_f, req1_ready);
            end
        end
        f = rsp0_f;
        rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        pop_exp(e);
        total++;
        if (f !== e.f) begin
            bad++;
            $display("FAIL bp_result: f=%h want %h", f, e.f);
        end
        issue(1'b1, OC_ADD, 16'd5, 16'd6, ok, hs, tries, orr);
        sb.push_back('{1'b1, 16'd11, 1'b0});
        collect(1'b1, ok, vc, f, err, ov);
        pop_exp(e);
        total++;
        if (!ok || (vc - hs) != 2 || {f, err, ov} !== {e.f, e.err, 1'b0}) begin
            bad++;
            $display("FAIL bp_followup: ok=%0d lat=%0d f=%h want lat=2 f=%h", ok, vc - hs, f, e.f);
        end
    endtask

    task automatic test_reset_mid_exec();
        bit ok; int hs, tries, vc; logic orr, ov, err; logic [DW-1:0] f; exp_t e;
        issue(1'b1, OC_DIV, 16'd100, 16'd5, ok, hs, tries, orr);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, alu_oc, alu_a, alu_b} !== '0) begin
            bad++;
            $display("FAIL midrst_clear: v0=%b v1=%b oc=%h a=%h b=%h want all 0",
                     rsp0_valid, rsp1_valid, alu_oc, alu_a, alu_b);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, OC_ADD, 16'd1, 16'd1, ok, hs, tries, orr);
        sb.push_back('{1'b0, 16'd2, 1'b0});
        collect(1'b0, ok, vc, f, err, ov);
        pop_exp(e);
        total++;
        if (!ok || (vc - hs) != 2 || {f, err, ov} !== {e.f, e.err, 1'b0}) begin
            bad++;
            $display("FAIL midrst_next_op: ok=%0d lat=%0d f=%h other=%b want lat=2 f=%h other=0",
                     ok, vc - hs, f, ov, e.f);
        end
    endtask

    task automatic test_div_zero();
        bit ok; int hs, tries, vc; logic orr, ov, err; logic [DW-1:0] f; exp_t e;
        issue(1'b1, OC_DIV, 16'd5, 16'd0, ok, hs, tries, orr);
`ifdef ALU_ARB_DZ_EN
        sb.push_back('{1'b1, 16'h0000, 1'b1});
`else
        sb.push_back('{1'b1, 16'hFFFF, 1'b0});
`endif
        collect(1'b1, ok, vc, f, err, ov);
        pop_exp(e);
        total++;
        if (!ok || (vc - hs) != 5 || {f, err} !== {e.f, e.err}) begin
            bad++;
            $display("FAIL div_zero: ok=%0d lat=%0d f=%h err=%b want lat=5 f=%h err=%b",
                     ok, vc - hs, f, err, e.f, e.err);
        end
        @(negedge clk);
        #1;
        total++;
        if ({rsp0_err, rsp1_err} !== 2'b00) begin
            bad++;
            $display("FAIL div_zero_err_clear: got %b want 00", {rsp0_err, rsp1_err});
        end
    endtask

    initial begin
        req0_valid = 1'b0; req0_oc = '0; req0_a = '0; req0_b = '0; rsp0_ready = 1'b1;
        req1_valid = 1'b0; req1_oc = '0; req1_a = '0; req1_b = '0; rsp1_ready = 1'b1;
        test_reset();
        test_contention();
        test_slow_op();
        test_backpressure();
        test_reset_mid_exec();
        test_div_zero();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance between two requesters (CPU execute stage and a DMA/address-calc unit) using a valid/ready request channel and a valid/ready response channel per requester. Registers operands, drives the alu, waits a per-opcode number of cycles so MUL/DIV can run as multicycle paths, then returns the registered result to the granted requester. Round-robin arbitration. One operation in flight.

Parameters:
DATA_WIDTH, 16, width of operands and result
FAST_LAT, 1, EXEC cycles for ADD/SUB/NOT/XOR/OR/AND (>=1)
SLOW_LAT, 4, EXEC cycles for MUL (3'b010) and DIV (3'b011) (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_oc  in  3  requester 0 opcode (alu encoding)
req0_a  in  DATA_WIDTH  requester 0 operand a
req0_b  in  DATA_WIDTH  requester 0 operand b
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp0_f  out  DATA_WIDTH  result to requester 0
rsp0_err  out  1  divide-by-zero flag (optional feature)
req1_*/rsp1_*  same as requester 0, for requester 1
alu_oc  out  3  to alu oc
alu_a  out  DATA_WIDTH  to alu a
alu_b  out  DATA_WIDTH  to alu b
alu_f  in  DATA_WIDTH  from alu f

Behaviour:
- Async reset (rst_n low, any time incl. mid-operation): state IDLE, op/result regs 0, alu_oc/a/b 0, all req*_ready 0, rsp*_valid 0, rsp*_f 0, rsp*_err 0, last_grant=1 (requester 0 wins first). In-flight op discarded, no response.
- States: IDLE, EXEC, RESP.
- IDLE: grant = req with valid; both valid -> the one != last_grant. reqN_ready is combinational, high only in IDLE for granted N. On handshake edge: latch oc/a/b into op regs, owner=N, load counter with FAST_LAT or SLOW_LAT by oc, -> EXEC. No valid -> stay.
- alu_oc/alu_a/alu_b driven directly from op regs (stable throughout EXEC).
- EXEC: counter decrements each cycle; in the cycle counter==1, latch alu_f into result reg, -> RESP. Latency: handshake cycle T -> rspN_valid high from T+1+LAT.
- RESP: rsp{owner}_valid=1, other rsp valid=0; rsp*_f shows result reg. Hold until rsp{owner}_ready; on that edge last_grant=owner, -> IDLE. No accept during RESP (ready=0 in EXEC/RESP).
- Peak throughput: one op per LAT+2 cycles with rsp_ready tied high.
- Requester may drop valid before ready without effect; after handshake, input changes ignored.
- Widths: result truncated to DATA_WIDTH as alu produces; no carry/overflow outputs.

Optional Feature:
ALU_ARB_DZ_EN: defined -> when latched oc==3'b011 and b==0, result reg loads 0 instead of alu_f and rsp{owner}_err=1 during RESP (0 otherwise); timing unchanged. Undefined -> alu_f passed unmodified, rsp*_err tied 0.

Decomposition:
- Package pico_alu_pkg: opcode constants OC_ADD..OC_AND (3'b000..3'b111), state encoding IDLE/EXEC/RESP, is_slow_op function (oc==OC_MUL||oc==OC_DIV).
- Sub-module alu_rr_arbiter: 2-way round-robin grant from valid vector + last_grant; combinational, reused later for memory port sharing.

Test Plan:
- Reset: rst_n low -> all outputs 0; release, req0 ADD a=3 b=4 -> req0_ready same cycle, rsp0_valid 2 cycles later, rsp0_f=7.
- Contention: both valid from reset, req0 SUB 10-3, req1 AND 0xF0F0&0x0FF0 -> req0 served first (7), then req1 (0x00F0); repeat with both valid -> req0 again after req1 (alternation).
- Slow op: req1 DIV 100/7 -> rsp1_valid 5 cycles after handshake, rsp1_f=14; MUL 300*300 -> 0x5F90 (truncated 90000).
- Backpressure: rsp0_ready low 10 cycles -> rsp0_valid and f held, req1_ready stays 0, then completes.
- Reset mid-EXEC of DIV -> no rsp, next op 1+1 served normally (f=2).
- ALU_ARB_DZ_EN: DIV 5/0 -> rsp_f=0, rsp_err=1; without macro rsp_err=0, f=alu value.
